evr_map_decoder: RTL and testbench
==================================

# evr_map_decoder

Event-code decoder on the read side of the EVR mapping RAM. It takes the stream of received event codes and drives the RAM read address. It registers the 16-bit mapping word that comes back and turns each set bit into a fixed-width output pulse. It also keeps a saturating count of decoded events. It sits between the event receiver's code output and the pulse/trigger outputs, and shares the RAM read port with nothing else.

## Interface
Parameters:
- PULSE_WIDTH, 4: output pulse length in clk_i cycles; legal range 1..255.
- NULL_CODE, 8'h00: event code that is never decoded.

Ports:
- clk_i  in  1  system clock (event clock domain); the mapping RAM read port runs on the same clock.
- rst_i  in  1  reset; asynchronous and active-high.
- event_code  in  8  received event code.
- event_valid  in  1  event_code qualifier; may be high on consecutive cycles.
- map_busy  in  1  high while the mapping RAM clear sequence runs (clear requested, not yet ready); suppresses decoding.
- rdaddr  out  8  mapping RAM read address.
- RAMout  in  16  mapping word from the RAM. It is registered in the RAM and valid one cycle after rdaddr is presented. It reads zero when the RAM is disabled.
- trig_o  out  16  per-bit output pulses.
- trig_strobe_o  out  1  one-cycle strobe marking the cycle a mapping word is applied.
- evt_count_o  out  16  number of decoded (non-null, non-suppressed) events, saturating.

## Operation
- Stage 0 (accept): on clk_i, if event_valid && event_code != NULL_CODE && !map_busy, set v1<=1 and rdaddr<=event_code; otherwise v1<=0 and rdaddr holds its value.
- Stage 1 (RAM access): v2<=v1. The RAM presents its registered doutb for rdaddr.
- Stage 2 (capture): if v2, map_q<=RAMout and trig_strobe_o<=1; else trig_strobe_o<=0.
- Stage 3 (pulse): each bit i has an 8-bit down-counter cnt[i].
  - If trig_strobe_o && map_q[i], then cnt[i]<=PULSE_WIDTH.
  - Else if cnt[i]!=0, then cnt[i]<=cnt[i]-1.
  - trig_o[i] is registered: trig_o[i]<=(next cnt[i]!=0).
- Retrigger: a new strobe while a bit is active reloads that bit to PULSE_WIDTH. Pulses are not additive and no gap is inserted.
- Counter: evt_count_o increments when v1 goes high. It saturates at 16'hFFFF and never wraps.
- map_busy asserted mid-pipeline: events already in v1/v2 complete normally. Only new acceptance is blocked.
- Zero mapping word: trig_strobe_o still pulses and trig_o is unchanged.

## Timing
- Reset values: rdaddr=0, trig_o=0, trig_strobe_o=0, evt_count_o=0; internal v1, v2, map_q and all cnt[i] are 0.
- Reset mid-operation clears all pulses immediately (asynchronously). No event in flight survives reset.
- Latency, event_valid (cycle 0) to trig_strobe_o: 3 rising edges.
- Latency, event_valid to trig_o rising: 4 rising edges.
- trig_o[i] stays high for exactly PULSE_WIDTH cycles after its last trigger.
- Throughput: one event per cycle. Back-to-back events produce consecutive strobes.
- The RAM is assumed to have exactly 1 cycle of read latency. This is a hard interface contract with the mapping RAM instance.

## Structure
- Shared EVR package holds:
  - event-code width (8) and mapping-word width (16);
  - the NULL_CODE default;
  - the RAM read-latency constant (1).
- One natural sub-module: evr_pulse_stretch, a single-bit reloadable down-counter with registered output, instantiated 16 times by a generate loop.
- The pipeline stages and the event counter stay in the top module.

## Test plan
- Single event: RAM[0x12]=16'h0005, PULSE_WIDTH=4, event 0x12 at cycle 0.
  - rdaddr=0x12 after edge 1 and trig_strobe_o high after edge 3.
  - trig_o[0] and trig_o[2] high for edges 4..7, all other bits 0.
  - evt_count_o=1.
- Null and busy:
  - event 0x00 -> no rdaddr change, no strobe, count unchanged.
  - event 0x12 with map_busy=1 -> same result.
- Back-to-back: events 0x01 (map 16'h0001) and 0x02 (map 16'h0001) on consecutive cycles.
  - Two strobes on consecutive cycles.
  - trig_o[0] high for 5 cycles, continuous (reload).
  - evt_count_o=2.
- Saturation: preload evt_count_o=16'hFFFE via 3 events after forcing, or run 65537 events -> evt_count_o stops at 16'hFFFF.
- Reset mid-pulse: assert rst_i while trig_o=16'h0005 -> trig_o=0 immediately, strobe 0, count 0. After release, the next event decodes normally.
- Disabled RAM (RAMout=0) -> strobe occurs, trig_o stays 0.

Source files
------------

// File: rtl/evr_map_decoder_pkg.sv
// -----------------------------------------------------------------------------
// evr_map_decoder_pkg
// Shared EVR constants used by the mapping-RAM read-side decoder.
//   EVT_CODE_W        : width of a received event code
//   MAP_W             : width of a mapping-RAM word (one bit per trigger output)
//   NULL_CODE_DEFAULT : event code that is never decoded
//   RAM_RD_LATENCY    : read latency of the mapping RAM in clk_i cycles; the
//                       decoder pipeline is built around exactly this value
//   CNT_W / CNT_MAX   : width and saturation value of the decoded-event counter
// -----------------------------------------------------------------------------
package evr_map_decoder_pkg;

    localparam int EVT_CODE_W     = 8;
    localparam int MAP_W          = 16;
    localparam int RAM_RD_LATENCY = 1;
    localparam int CNT_W          = 16;

    localparam logic [EVT_CODE_W-1:0] NULL_CODE_DEFAULT = 8'h00;
    localparam logic [CNT_W-1:0]      CNT_MAX           = '1;

    // Saturating increment for the decoded-event counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/evr_pulse_stretch.sv
// -----------------------------------------------------------------------------
// evr_pulse_stretch
// Single-bit reloadable pulse stretcher. A load reloads the down-counter to
// PULSE_WIDTH (retrigger while active simply restarts the pulse); otherwise the
// counter decays to zero. The output is registered from the next counter value,
// so it rises on the edge after load and stays high for PULSE_WIDTH cycles.
// Ports:
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   load_i  : reload the counter this cycle
//   pulse_o : registered stretched pulse
// -----------------------------------------------------------------------------
module evr_pulse_stretch #(
    parameter int PULSE_WIDTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic pulse_o
);

    localparam logic [7:0] WIDTH = 8'(PULSE_WIDTH);

    logic [7:0] cnt;
    logic [7:0] cnt_nxt;

    always_comb begin
        // NOTE: default first so every path assigns cnt_nxt; otherwise a latch is inferred.
        cnt_nxt = cnt;
        if (load_i) begin
            cnt_nxt = WIDTH;
        end else if (cnt != 8'd0) begin
            cnt_nxt = cnt - 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt     <= 8'd0;
            pulse_o <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            pulse_o <= (cnt_nxt != 8'd0);
        end
    end

endmodule

// File: rtl/evr_map_decoder.sv
// -----------------------------------------------------------------------------
// evr_map_decoder
// Read side of the EVR mapping RAM. Accepted event codes become the RAM read
// address; the returned mapping word is captured and each set bit fires a
// fixed-width pulse on trig_o. Also counts decoded events (saturating).
//   stage 0 : accept event, drive rdaddr           (v1)
//   stage 1 : RAM registered read                  (v2)
//   stage 2 : capture RAMout into map_q, strobe
//   stage 3 : per-bit pulse stretchers -> trig_o
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   event_code     : received event code
//   event_valid    : event_code qualifier
//   map_busy       : mapping RAM clear in progress; blocks new acceptance only
//   rdaddr         : mapping RAM read address
//   RAMout         : mapping word, valid one cycle after rdaddr
//   trig_o         : per-bit output pulses
//   trig_strobe_o  : one-cycle strobe when a mapping word is applied
//   evt_count_o    : saturating count of decoded events
// -----------------------------------------------------------------------------
module evr_map_decoder
    import evr_map_decoder_pkg::*;
#(
    parameter int                    PULSE_WIDTH = 4,
    parameter logic [EVT_CODE_W-1:0] NULL_CODE   = NULL_CODE_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [EVT_CODE_W-1:0] event_code,
    input  logic                  event_valid,
    input  logic                  map_busy,
    output logic [EVT_CODE_W-1:0] rdaddr,
    input  logic [MAP_W-1:0]      RAMout,
    output logic [MAP_W-1:0]      trig_o,
    output logic                  trig_strobe_o,
    output logic [CNT_W-1:0]      evt_count_o
);

    logic             accept;
    logic             v1;
    logic             v2;
    logic [MAP_W-1:0] map_q;

    assign accept = event_valid && (event_code != NULL_CODE) && !map_busy;

    // v2 aligns with RAMout because the RAM adds exactly RAM_RD_LATENCY (1)
    // cycle between rdaddr and its data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1            <= 1'b0;
            v2            <= 1'b0;
            rdaddr        <= '0;
            map_q         <= '0;
            trig_strobe_o <= 1'b0;
            evt_count_o   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the previous
            // cycle's value of the stage before it.
            v1 <= accept;
            if (accept) begin
                rdaddr      <= event_code;
                evt_count_o <= sat_inc(evt_count_o);
            end
            v2 <= v1;
            if (v2) begin
                map_q <= RAMout;
            end
            trig_strobe_o <= v2;
        end
    end

    for (genvar i = 0; i < MAP_W; i++) begin : g_pulse
        evr_pulse_stretch #(
            .PULSE_WIDTH (PULSE_WIDTH)
        ) u_pulse (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .load_i  (trig_strobe_o && map_q[i]),
            .pulse_o (trig_o[i])
        );
    end

endmodule

// File: tb/tb_evr_map_decoder.sv
module tb_evr_map_decoder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  event_code;
    logic        event_valid;
    logic        map_busy;
    logic [7:0]  rdaddr;
    logic [15:0] RAMout;
    logic [15:0] trig_o;
    logic        trig_strobe_o;
    logic [15:0] evt_count_o;

    int tests  = 0;
    int failed = 0;

    // Mapping RAM model: registered read, zero when disabled.
    logic [15:0] mem [256];
    logic        ram_en;
    logic [15:0] ram_q;

    always #5 clk_i = ~clk_i;

    always_ff @(posedge clk_i) ram_q <= ram_en ? mem[rdaddr] : 16'h0000;
    assign RAMout = ram_q;

    evr_map_decoder #(
        .PULSE_WIDTH (4),
        .NULL_CODE   (8'h00)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .event_code    (event_code),
        .event_valid   (event_valid),
        .map_busy      (map_busy),
        .rdaddr        (rdaddr),
        .RAMout        (RAMout),
        .trig_o        (trig_o),
        .trig_strobe_o (trig_strobe_o),
        .evt_count_o   (evt_count_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send(input logic [7:0] code);
        event_code  = code;
        event_valid = 1'b1;
    endtask

    task automatic idle();
        event_valid = 1'b0;
        event_code  = 8'h00;
    endtask

    initial begin
        logic [15:0] exp_count;

        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
        mem[8'h12] = 16'h0005;
        mem[8'h01] = 16'h0001;
        mem[8'h02] = 16'h0001;
        ram_en      = 1'b1;
        rst_i       = 1'b1;
        map_busy    = 1'b0;
        idle();
        ticks(2);

        check("reset_rdaddr", 32'(rdaddr), 32'h00);
        check("reset_trig", 32'(trig_o), 32'h0000);
        check("reset_strobe", 32'(trig_strobe_o), 32'h0);
        check("reset_count", 32'(evt_count_o), 32'h0000);

        #2 rst_i = 1'b0;
        tick();

        // Single event 0x12 -> map 0x0005.
        send(8'h12);
        tick();                                        // edge 1
        idle();
        check("single_rdaddr_e1", 32'(rdaddr), 32'h12);
        check("single_count", 32'(evt_count_o), 32'h0001);
        check("single_strobe_e1", 32'(trig_strobe_o), 32'h0);
        tick();                                        // edge 2
        check("single_strobe_e2", 32'(trig_strobe_o), 32'h0);
        tick();                                        // edge 3
        check("single_strobe_e3", 32'(trig_strobe_o), 32'h1);
        check("single_trig_e3", 32'(trig_o), 32'h0000);
        for (int e = 4; e <= 7; e++) begin
            tick();
            check($sformatf("single_trig_e%0d", e), 32'(trig_o), 32'h0005);
            check($sformatf("single_strobe_e%0d", e), 32'(trig_strobe_o), 32'h0);
        end
        tick();                                        // edge 8
        check("single_trig_e8", 32'(trig_o), 32'h0000);
        exp_count = 16'h0001;

        // Null code: nothing happens.
        send(8'h00);
        tick();
        idle();
        check("null_rdaddr", 32'(rdaddr), 32'h12);
        check("null_count", 32'(evt_count_o), 32'(exp_count));
        for (int e = 2; e <= 5; e++) begin
            tick();
            check($sformatf("null_strobe_e%0d", e), 32'(trig_strobe_o), 32'h0);
            check($sformatf("null_trig_e%0d", e), 32'(trig_o), 32'h0000);
        end

        // Busy: event 0x34 is blocked (rdaddr would otherwise change).
        map_busy = 1'b1;
        send(8'h34);
        tick();
        idle();
        check("busy_rdaddr", 32'(rdaddr), 32'h12);
        check("busy_count", 32'(evt_count_o), 32'(exp_count));
        for (int e = 2; e <= 5; e++) begin
            tick();
            check($sformatf("busy_strobe_e%0d", e), 32'(trig_strobe_o), 32'h0);
            check($sformatf("busy_trig_e%0d", e), 32'(trig_o), 32'h0000);
        end

        // Busy raised after acceptance: the in-flight event still completes.
        map_busy = 1'b0;
        send(8'h12);
        tick();                                        // edge 1
        idle();
        map_busy = 1'b1;
        ticks(2);                                      // edge 3
        check("midbusy_strobe", 32'(trig_strobe_o), 32'h1);
        tick();
        check("midbusy_trig", 32'(trig_o), 32'h0005);
        map_busy = 1'b0;
        exp_count = exp_count + 16'd1;
        check("midbusy_count", 32'(evt_count_o), 32'(exp_count));
        ticks(5);
        check("midbusy_trig_done", 32'(trig_o), 32'h0000);

        // Back-to-back 0x01, 0x02 (both map bit 0): reload, 5-cycle pulse.
        send(8'h01);
        tick();                                        // edge 1
        send(8'h02);
        tick();                                        // edge 2
        idle();
        check("b2b_rdaddr", 32'(rdaddr), 32'h02);
        exp_count = exp_count + 16'd2;
        check("b2b_count", 32'(evt_count_o), 32'(exp_count));
        tick();                                        // edge 3
        check("b2b_strobe_e3", 32'(trig_strobe_o), 32'h1);
        tick();                                        // edge 4
        check("b2b_strobe_e4", 32'(trig_strobe_o), 32'h1);
        check("b2b_trig_e4", 32'(trig_o), 32'h0001);
        for (int e = 5; e <= 8; e++) begin
            tick();
            check($sformatf("b2b_trig_e%0d", e), 32'(trig_o), 32'h0001);
        end
        check("b2b_strobe_e8", 32'(trig_strobe_o), 32'h0);
        tick();                                        // edge 9
        check("b2b_trig_e9", 32'(trig_o), 32'h0000);

        // Disabled RAM: strobe still fires, no pulses.
        ram_en = 1'b0;
        send(8'h12);
        tick();
        idle();
        ticks(2);                                      // edge 3
        check("noram_strobe", 32'(trig_strobe_o), 32'h1);
        tick();
        check("noram_trig_e4", 32'(trig_o), 32'h0000);
        tick();
        check("noram_trig_e5", 32'(trig_o), 32'h0000);
        ram_en = 1'b1;
        exp_count = exp_count + 16'd1;
        check("noram_count", 32'(evt_count_o), 32'(exp_count));
        ticks(3);

        // Reset mid-pulse clears everything without a clock edge.
        send(8'h12);
        tick();
        idle();
        ticks(4);                                      // edge 5
        check("prerst_trig", 32'(trig_o), 32'h0005);
        #2 rst_i = 1'b1;
        #1;
        check("rst_async_trig", 32'(trig_o), 32'h0000);
        check("rst_async_strobe", 32'(trig_strobe_o), 32'h0);
        check("rst_async_count", 32'(evt_count_o), 32'h0000);
        check("rst_async_rdaddr", 32'(rdaddr), 32'h00);
        tick();
        #2 rst_i = 1'b0;
        ticks(2);
        check("postrst_trig", 32'(trig_o), 32'h0000);

        // Decode after reset release.
        send(8'h12);
        tick();
        idle();
        check("postrst_rdaddr", 32'(rdaddr), 32'h12);
        check("postrst_count", 32'(evt_count_o), 32'h0001);
        ticks(2);
        check("postrst_strobe", 32'(trig_strobe_o), 32'h1);
        tick();
        check("postrst_trig_on", 32'(trig_o), 32'h0005);
        ticks(4);
        check("postrst_trig_off", 32'(trig_o), 32'h0000);

        // Saturation: count from 1 up to 0xFFFE, 0xFFFF, then hold.
        send(8'h01);
        ticks(65533);
        idle();
        check("sat_fffe", 32'(evt_count_o), 32'hFFFE);
        send(8'h01);
        tick();
        idle();
        check("sat_ffff", 32'(evt_count_o), 32'hFFFF);
        send(8'h02);
        ticks(3);
        idle();
        check("sat_hold", 32'(evt_count_o), 32'hFFFF);
        ticks(10);
        check("sat_trig_done", 32'(trig_o), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
